subtractor_8b: RTL and testbench
================================

# subtractor_8b

Unsigned 8-bit ripple-borrow subtractor computing A − B with a borrow-out flag, for datapath blocks that need a magnitude comparison or modular difference. Combinational outputs S/Borrow settle within the same cycle. Registered copies (S_q/Borrow_q) give a clean one-cycle-latency pipelined result to downstream synchronous logic.

## Interface
- WIDTH, 8: operand and result width. Only 8 is required and verified; other values must elaborate.
- clk  input  1  rising-edge clock for the output registers.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  minuend, unsigned.
- B  input  WIDTH  subtrahend, unsigned.
- S  output  WIDTH  combinational difference, (A − B) mod 2^WIDTH.
- Borrow  output  1  combinational borrow-out; 1 iff A < B (unsigned).
- S_q  output  WIDTH  S registered on clk.
- Borrow_q  output  1  Borrow registered on clk.

## Operation
- Ripple-borrow chain of WIDTH full-subtractor cells, LSB first; borrow-in of bit 0 is tied 0.
- Each cell computes:
  - d = a ^ b ^ bin
  - bout = (~a & b) | (~(a ^ b) & bin)
- S = concatenation of all cell d outputs. Borrow = bout of the MSB cell.
- The result is two's-complement wraparound. Example: 5 − 10 gives S = 251 (8'b1111_1011), Borrow = 1.
- A == B gives S = 0, Borrow = 0. B == 0 gives S = A, Borrow = 0.
- No signed interpretation or overflow flag; Borrow is the only status output.
- S and Borrow depend only on A and B. They are unaffected by clk and rst.

## Timing
- Combinational path: S/Borrow valid after ripple propagation, with no clock edge required. Worst case is the full WIDTH-bit borrow ripple, e.g. 0 − 1.
- Registered path: on each rising clk edge:
  - rst = 1: S_q ← 0, Borrow_q ← 0.
  - otherwise: S_q ← S, Borrow_q ← Borrow.
- Latency of S_q/Borrow_q is 1 cycle from an operand change sampled at the edge.
- Reset values: S_q = 0, Borrow_q = 0. S/Borrow have no reset value; they track the inputs.
- Reset mid-operation: registers clear on the next edge regardless of operands. The first post-reset edge captures the current A/B result.
- Operands changing every cycle: each edge captures the result of the operands present before that edge. No stalls, no handshake.

## Structure
- Shared package holds the constant DATA_W = 8, used as the WIDTH default.
- One sub-module: full_subtractor with ports a, b, bin, d, bout. It is instantiated WIDTH times via a generate loop.
- The top level contains:
  - the generate chain
  - the borrow wiring
  - one clocked always block for S_q/Borrow_q with synchronous reset

## Test plan
- A=10, B=3 -> S=7 (0000_0111), Borrow=0; after one clk edge S_q=7, Borrow_q=0.
- A=5, B=10 -> S=251 (1111_1011), Borrow=1; registered copies match after one edge.
- A=255, B=1 -> S=254, Borrow=0. Also check A=0, B=1 -> S=255, Borrow=1 (full ripple).
- A=0, B=0 and A=100, B=100 -> S=0, Borrow=0 in both cases.
- Assert rst for one edge with A=5, B=10 -> S_q=0, Borrow_q=0 while S=251, Borrow=1 still show combinationally. Deassert -> next edge S_q=251, Borrow_q=1.
- Random sweep, ≥1000 pairs. Compare S against (A−B)&8'hFF and Borrow against (A<B) every cycle. Compare S_q/Borrow_q against the previous cycle's expected values.

Source files
------------

// File: rtl/subtractor_8b_pkg.sv
// Shared constants for the unsigned ripple-borrow subtractor.
package subtractor_8b_pkg;

  localparam int DATA_W = 8;

endpackage

// File: rtl/subtractor_8b_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtractor_8b.sv
// Unsigned WIDTH-bit ripple-borrow subtractor (A - B) with combinational
// result/borrow and a one-cycle registered copy.
module subtractor_8b
  import subtractor_8b_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Borrow,
  output logic [WIDTH-1:0] S_q,
  output logic             Borrow_q
);

  // borrow_chain[i] is the borrow into bit i; the LSB never borrows in.
  logic [WIDTH:0] borrow_chain;

  assign borrow_chain[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor u_cell (
      .a    (A[i]),
      .b    (B[i]),
      .bin  (borrow_chain[i]),
      .d    (S[i]),
      .bout (borrow_chain[i+1])
    );
  end

  assign Borrow = borrow_chain[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      S_q      <= '0;
      Borrow_q <= 1'b0;
    end else begin
      S_q      <= S;
      Borrow_q <= Borrow;
    end
  end

endmodule

// File: tb/tb_subtractor_8b.sv
// Self-checking bench for subtractor_8b: directed table, reset sequence and
// a random sweep against an arithmetic reference.
module tb_subtractor_8b;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] S;
  logic       Borrow;
  logic [7:0] S_q;
  logic       Borrow_q;

  int checks;
  int errors;

  typedef struct {
    int a;
    int b;
    int exp_s;
    int exp_borrow;
  } vec_t;

  vec_t vecs[8];

  subtractor_8b dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .S        (S),
    .Borrow   (Borrow),
    .S_q      (S_q),
    .Borrow_q (Borrow_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: modular difference and unsigned less-than, plain arithmetic.
  function automatic int ref_s(input int a, input int b);
    return (a - b) & 8'hFF;
  endfunction

  function automatic int ref_borrow(input int a, input int b);
    return (a < b) ? 1 : 0;
  endfunction

  initial begin
    int ra, rb, es, eb;
    checks = 0;
    errors = 0;

    vecs[0] = '{10, 3, 7, 0};
    vecs[1] = '{5, 10, 251, 1};
    vecs[2] = '{255, 1, 254, 0};
    vecs[3] = '{0, 1, 255, 1};
    vecs[4] = '{0, 0, 0, 0};
    vecs[5] = '{100, 100, 0, 0};
    vecs[6] = '{77, 0, 77, 0};
    vecs[7] = '{0, 255, 1, 1};

    rst = 1'b1;
    A   = 8'd0;
    B   = 8'd0;
    @(posedge clk);
    #1;
    check("reset_s_q", int'(S_q), 0);
    check("reset_borrow_q", int'(Borrow_q), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      A = 8'(vecs[i].a);
      B = 8'(vecs[i].b);
      #1;
      check($sformatf("vec%0d_s", i), int'(S), vecs[i].exp_s);
      check($sformatf("vec%0d_borrow", i), int'(Borrow), vecs[i].exp_borrow);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_s_q", i), int'(S_q), vecs[i].exp_s);
      check($sformatf("vec%0d_borrow_q", i), int'(Borrow_q), vecs[i].exp_borrow);
    end

    // Reset while operands stay live: combinational path unaffected.
    A = 8'd200;
    B = 8'd13;
    @(posedge clk);
    #1;
    check("pre_rst_s_q", int'(S_q), 187);
    A   = 8'd5;
    B   = 8'd10;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_s_q", int'(S_q), 0);
    check("rst_borrow_q", int'(Borrow_q), 0);
    check("rst_s_comb", int'(S), 251);
    check("rst_borrow_comb", int'(Borrow), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_s_q", int'(S_q), 251);
    check("post_rst_borrow_q", int'(Borrow_q), 1);

    // Operands change every cycle; each edge captures the prior operands.
    for (int n = 0; n < 1200; n++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      if (n % 50 == 0) rb = ra;
      if (n % 50 == 1) rb = 0;
      es = ref_s(ra, rb);
      eb = ref_borrow(ra, rb);
      A = 8'(ra);
      B = 8'(rb);
      #1;
      check("rand_s", int'(S), es);
      check("rand_borrow", int'(Borrow), eb);
      @(posedge clk);
      #1;
      check("rand_s_q", int'(S_q), es);
      check("rand_borrow_q", int'(Borrow_q), eb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
